// File: rtl/rv_alu1_pipe.sv
// ============================================================================
// rv_alu1_pipe : decode-to-ALU stage register with 2-entry skid buffer,
//                operand selection and jump/branch/mret target computation.
// Optional: `define RV_ALU1_PIPE_MISALIGN_EN adds o_misalign.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_alu1_pipe #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int XLEN             = 32,
    parameter int CTRL_W           = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
    input  logic                        i_branch_pred,
    input  logic [4:0]                  i_rd,
    input  logic                        i_reg_write,
    input  logic [XLEN-1:0]             i_imm_i,
    input  logic [XLEN-1:0]             i_imm_j,
    input  logic [2:0]                  i_op_sel,
    input  logic [4:0]                  i_inst,
    input  logic [CTRL_W-1:0]           i_ctrl,
    input  logic [IADDR_SPACE_BITS-1:0] i_ret_addr,
    input  logic [XLEN-1:0]             i_reg1_data,
    input  logic [XLEN-1:0]             i_reg2_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [XLEN-1:0]             o_op1,
    output logic [XLEN-1:0]             o_op2,
    output logic [XLEN-1:0]             o_reg_data2,
    output logic [4:0]                  o_rd,
    output logic                        o_reg_write,
    output logic [CTRL_W-1:0]           o_ctrl,
    output logic [4:0]                  o_inst,
    output logic [IADDR_SPACE_BITS-1:0] o_pc,
    output logic [IADDR_SPACE_BITS-1:0] o_pc_next,
    output logic                        o_branch_pred,
    output logic [IADDR_SPACE_BITS-1:0] o_pc_target,
`ifdef RV_ALU1_PIPE_MISALIGN_EN
    output logic                        o_misalign,
`endif
    output logic                        o_jump_mispred
);

    localparam int         c_JAL    = 0;
    localparam int         c_JALR   = 1;
    localparam int         c_MRET   = 2;
    localparam int         c_BRANCH = 3;
    localparam int         c_OP1_PC = 0;
    localparam int         c_OP2_I  = 1;
    localparam int         c_OP2_J  = 2;

    // Buffer state encoded as {S.valid, M.valid}
    localparam logic [1:0] c_EMPTY  = 2'b00;
    localparam logic [1:0] c_ONE    = 2'b01;
    localparam logic [1:0] c_FULL   = 2'b11;

    typedef struct packed {
        logic [IADDR_SPACE_BITS-1:0] pc;
        logic [IADDR_SPACE_BITS-1:0] pc_next;
        logic                        branch_pred;
        logic [4:0]                  rd;
        logic                        reg_write;
        logic [XLEN-1:0]             imm_i;
        logic [XLEN-1:0]             imm_j;
        logic [2:0]                  op_sel;
        logic [4:0]                  inst;
        logic [CTRL_W-1:0]           ctrl;
        logic [IADDR_SPACE_BITS-1:0] ret_addr;
        logic [XLEN-1:0]             reg1;
        logic [XLEN-1:0]             reg2;
    } payload_t;

    payload_t r_m, r_s, w_in;
    logic     r_m_valid, r_s_valid, r_ready;
    logic     w_m_valid_nxt, w_s_valid_nxt;
    logic     w_load_m_in, w_load_m_s, w_load_s;
    logic     w_in_xfer, w_out_xfer;

    always_comb begin
        w_in.pc          = i_pc;
        w_in.pc_next     = i_pc_next;
        w_in.branch_pred = i_branch_pred;
        w_in.rd          = i_rd;
        w_in.reg_write   = i_reg_write;
        w_in.imm_i       = i_imm_i;
        w_in.imm_j       = i_imm_j;
        w_in.op_sel      = i_op_sel;
        w_in.inst        = i_inst;
        w_in.ctrl        = i_ctrl;
        w_in.ret_addr    = i_ret_addr;
        w_in.reg1        = i_reg1_data;
        w_in.reg2        = i_reg2_data;
    end

    assign w_in_xfer  = i_valid & r_ready;
    assign w_out_xfer = r_m_valid & i_ready;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_load_m_in   = 1'b0;
        w_load_m_s    = 1'b0;
        w_load_s      = 1'b0;
        case ({r_s_valid, r_m_valid})
            c_EMPTY: begin
                if (w_in_xfer) begin
                    w_m_valid_nxt = 1'b1;
                    w_load_m_in   = 1'b1;
                end
            end
            c_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_m_in   = 1'b1;
                end else if (w_in_xfer) begin
                    w_s_valid_nxt = 1'b1;
                    w_load_s      = 1'b1;
                end else if (w_out_xfer) begin
                    w_m_valid_nxt = 1'b0;
                end
            end
            c_FULL: begin
                if (w_out_xfer) begin
                    w_load_m_s    = 1'b1;
                    w_s_valid_nxt = 1'b0;
                end
            end
            default: begin
                // {1,0} is unreachable; recover to empty
                w_m_valid_nxt = 1'b0;
                w_s_valid_nxt = 1'b0;
            end
        endcase
        if (i_flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
            r_m       <= '0;
            r_s       <= '0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_ready   <= ~w_s_valid_nxt;
            if (w_load_m_in) begin
                r_m <= w_in;
            end else if (w_load_m_s) begin
                r_m <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_in;
            end
        end
    end

    logic [XLEN-1:0]             w_pc_ext;
    logic [IADDR_SPACE_BITS-1:0] w_base, w_offset, w_target;
    logic                        w_is_jump;

    always_comb begin
        w_pc_ext                         = '0;
        w_pc_ext[IADDR_SPACE_BITS-1:0]   = r_m.pc;
        if (r_m.inst[c_MRET]) begin
            w_base   = r_m.ret_addr;
            w_offset = '0;
        end else if (r_m.inst[c_JALR]) begin
            w_base   = r_m.reg1[IADDR_SPACE_BITS-1:0];
            w_offset = r_m.imm_i[IADDR_SPACE_BITS-1:0];
        end else begin
            w_base   = r_m.pc;
            w_offset = r_m.imm_j[IADDR_SPACE_BITS-1:0];
        end
        w_target = w_base + w_offset;
        if (r_m.inst[c_JALR]) begin
            w_target[0] = 1'b0;
        end
    end

    assign w_is_jump = r_m.inst[c_JAL] | r_m.inst[c_JALR] | r_m.inst[c_MRET];

    assign o_ready       = r_ready;
    assign o_valid       = r_m_valid;
    assign o_op1         = r_m.op_sel[c_OP1_PC] ? w_pc_ext : r_m.reg1;
    assign o_op2         = r_m.op_sel[c_OP2_I] ? r_m.imm_i :
                           r_m.op_sel[c_OP2_J] ? r_m.imm_j : r_m.reg2;
    assign o_reg_data2   = r_m.reg2;
    assign o_rd          = r_m.rd;
    assign o_reg_write   = r_m.reg_write;
    assign o_ctrl        = r_m.ctrl;
    assign o_inst        = r_m.inst;
    assign o_pc          = r_m.pc;
    assign o_pc_next     = r_m.pc_next;
    assign o_branch_pred = r_m.branch_pred;
    assign o_pc_target   = w_target;

`ifdef RV_ALU1_PIPE_MISALIGN_EN
    // A misaligned target traps, so the trap path owns the redirect
    assign o_misalign     = r_m_valid & (w_is_jump | r_m.inst[c_BRANCH]) & w_target[1];
    assign o_jump_mispred = r_m_valid & w_is_jump & ~o_misalign &
                            (~r_m.branch_pred | (w_target != r_m.pc_next));
`else
    assign o_jump_mispred = r_m_valid & w_is_jump &
                            (~r_m.branch_pred | (w_target != r_m.pc_next));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_alu1_pipe.sv
// ============================================================================
// tb_rv_alu1_pipe : directed self-checking bench for rv_alu1_pipe (16-bit PC).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_alu1_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        dut_ready;
    logic [15:0] pc = '0, pc_next = '0, ret_addr = '0;
    logic        pred = 1'b0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic [31:0] imm_i = '0, imm_j = '0, reg1 = '0, reg2 = '0;
    logic [2:0]  op_sel = '0;
    logic [4:0]  inst = '0;
    logic [15:0] ctrl = '0;
    logic        out_ready = 1'b0;

    logic        dut_valid, dut_reg_write, dut_pred, dut_mispred;
    logic [31:0] dut_op1, dut_op2, dut_rd2;
    logic [4:0]  dut_rd, dut_inst;
    logic [15:0] dut_ctrl, dut_pc, dut_pc_next, dut_target;
`ifdef RV_ALU1_PIPE_MISALIGN_EN
    logic        dut_misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rv_alu1_pipe #(.IADDR_SPACE_BITS(16), .XLEN(32), .CTRL_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush),
        .i_valid(in_valid), .o_ready(dut_ready),
        .i_pc(pc), .i_pc_next(pc_next), .i_branch_pred(pred),
        .i_rd(rd), .i_reg_write(reg_write),
        .i_imm_i(imm_i), .i_imm_j(imm_j), .i_op_sel(op_sel),
        .i_inst(inst), .i_ctrl(ctrl), .i_ret_addr(ret_addr),
        .i_reg1_data(reg1), .i_reg2_data(reg2),
        .o_valid(dut_valid), .i_ready(out_ready),
        .o_op1(dut_op1), .o_op2(dut_op2), .o_reg_data2(dut_rd2),
        .o_rd(dut_rd), .o_reg_write(dut_reg_write), .o_ctrl(dut_ctrl),
        .o_inst(dut_inst), .o_pc(dut_pc), .o_pc_next(dut_pc_next),
        .o_branch_pred(dut_pred), .o_pc_target(dut_target),
`ifdef RV_ALU1_PIPE_MISALIGN_EN
        .o_misalign(dut_misalign),
`endif
        .o_jump_mispred(dut_mispred)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] p, input logic [15:0] pn, input logic pr,
                         input logic [4:0] in_inst, input logic [2:0] os,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] ii, input logic [31:0] ij,
                         input logic [15:0] ra);
        in_valid  = 1'b1;
        pc        = p;
        pc_next   = pn;
        pred      = pr;
        inst      = in_inst;
        op_sel    = os;
        reg1      = r1;
        reg2      = r2;
        imm_i     = ii;
        imm_j     = ij;
        ret_addr  = ra;
        rd        = p[6:2];
        ctrl      = p ^ 16'hA5A5;
        reg_write = 1'b1;
    endtask

    logic [2:0]  s_sel [4] = '{3'b000, 3'b010, 3'b110, 3'b101};
    logic [31:0] s_op1 [4] = '{32'h11, 32'h11, 32'h11, 32'h10C};
    logic [31:0] s_op2 [4] = '{32'h22, 32'h33, 32'h33, 32'h44};

    initial begin
        // reset
        tick(); tick();
        chk("rst_valid", 64'(dut_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 64'(dut_ready), 64'd1);
        chk("rst_valid_rel", 64'(dut_valid), 64'd0);

        // streaming, four back-to-back ALU ops
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(16'(16'h100 + 4 * k), '0, 1'b0, 5'b00000, s_sel[k],
                  32'h11, 32'h22, 32'h33, 32'h44, '0);
            tick();
            chk("stream_valid", 64'(dut_valid), 64'd1);
            chk("stream_ready", 64'(dut_ready), 64'd1);
            chk("stream_pc", 64'(dut_pc), 64'(16'h100 + 4 * k));
            chk("stream_op1", 64'(dut_op1), 64'(s_op1[k]));
            chk("stream_op2", 64'(dut_op2), 64'(s_op2[k]));
        end
        chk("stream_rd", 64'(dut_rd), 64'd3);
        chk("stream_ctrl", 64'(dut_ctrl), 64'h A4A9);
        chk("stream_rd2", 64'(dut_rd2), 64'h22);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 64'(dut_valid), 64'd0);

        // back-pressure
        out_ready = 1'b0;
        offer(16'h300, '0, 1'b0, 5'b0, 3'b0, 32'h1, 32'h2, 32'h0, 32'h0, '0);
        tick();
        chk("bp_a_valid", 64'(dut_valid), 64'd1);
        chk("bp_a_ready", 64'(dut_ready), 64'd1);
        offer(16'h304, '0, 1'b0, 5'b0, 3'b0, 32'h3, 32'h4, 32'h0, 32'h0, '0);
        tick();
        chk("bp_full_ready", 64'(dut_ready), 64'd0);
        chk("bp_full_pc", 64'(dut_pc), 64'h300);
        offer(16'h308, '0, 1'b0, 5'b0, 3'b0, 32'h5, 32'h6, 32'h0, 32'h0, '0);
        tick();
        chk("bp_hold_pc", 64'(dut_pc), 64'h300);
        chk("bp_hold_ready", 64'(dut_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_pc", 64'(dut_pc), 64'h304);
        chk("bp_b_rd2", 64'(dut_rd2), 64'h4);
        chk("bp_b_ready", 64'(dut_ready), 64'd1);
        tick();
        chk("bp_c_pc", 64'(dut_pc), 64'h308);
        chk("bp_c_valid", 64'(dut_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(dut_valid), 64'd0);

        // jump targets
        offer(16'h200, 16'h240, 1'b1, 5'b00001, 3'b0, 32'h0, 32'h0, 32'h0, 32'h40, '0);
        tick();
        chk("jal_target", 64'(dut_target), 64'h240);
        chk("jal_ok", 64'(dut_mispred), 64'd0);
        offer(16'h200, 16'h204, 1'b1, 5'b00001, 3'b0, 32'h0, 32'h0, 32'h0, 32'h40, '0);
        tick();
        chk("jal_badpc", 64'(dut_mispred), 64'd1);
        offer(16'h200, 16'h240, 1'b0, 5'b00001, 3'b0, 32'h0, 32'h0, 32'h0, 32'h40, '0);
        tick();
        chk("jal_nopred", 64'(dut_mispred), 64'd1);
        offer(16'h200, 16'h1004, 1'b1, 5'b00010, 3'b0, 32'h1001, 32'h0, 32'h4, 32'h8, '0);
        tick();
        chk("jalr_target", 64'(dut_target), 64'h1004);
        chk("jalr_ok", 64'(dut_mispred), 64'd0);
        offer(16'h200, 16'h80, 1'b1, 5'b00100, 3'b0, 32'h0, 32'h0, 32'h4, 32'h40, 16'h80);
        tick();
        chk("mret_target", 64'(dut_target), 64'h80);
        chk("mret_ok", 64'(dut_mispred), 64'd0);
        offer(16'h200, 16'h204, 1'b0, 5'b01000, 3'b0, 32'h0, 32'h0, 32'h0, 32'h40, '0);
        tick();
        chk("br_target", 64'(dut_target), 64'h240);
        chk("br_nomispred", 64'(dut_mispred), 64'd0);
        offer(16'h200, 16'h0, 1'b0, 5'b00010, 3'b0, 32'h1002, 32'h0, 32'h4, 32'h0, '0);
        tick();
        chk("jalr_mis_target", 64'(dut_target), 64'h1006);
`ifdef RV_ALU1_PIPE_MISALIGN_EN
        chk("misalign_flag", 64'(dut_misalign), 64'd1);
        chk("misalign_mispred", 64'(dut_mispred), 64'd0);
`else
        chk("jalr_mis_mispred", 64'(dut_mispred), 64'd1);
`endif

        // 16-bit wrap and zero-extended PC operand
        offer(16'hFFF0, '0, 1'b0, 5'b0, 3'b001, 32'hDEAD, 32'h0, 32'h0, 32'h20, '0);
        tick();
        chk("wrap_target", 64'(dut_target), 64'h0010);
        chk("wrap_op1", 64'(dut_op1), 64'h0000FFF0);
        in_valid = 1'b0;
        tick();
        chk("wrap_idle_mispred", 64'(dut_mispred), 64'd0);

        // flush while FULL with a new entry offered
        out_ready = 1'b0;
        offer(16'h400, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        tick();
        offer(16'h404, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        tick();
        chk("fl_full", 64'(dut_ready), 64'd0);
        offer(16'h408, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(dut_valid), 64'd0);
        chk("fl_ready", 64'(dut_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no_stale", 64'(dut_valid), 64'd0);
        end

        // flush discards a same-cycle accepted input
        out_ready = 1'b0;
        offer(16'h500, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        tick();
        offer(16'h504, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl1_valid", 64'(dut_valid), 64'd0);
        tick();
        chk("fl1_no_stale", 64'(dut_valid), 64'd0);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        offer(16'h600, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        tick();
        offer(16'h604, '0, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, '0);
        tick();
        in_valid = 1'b0;
        chk("ar_full", 64'(dut_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(dut_valid), 64'd0);
        chk("ar_ready", 64'(dut_ready), 64'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ar_after", 64'(dut_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
